// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
//   Issue-side controller for the multicycle multiply/divide unit. It accepts
//   one MULT/DIV from execute, latches the operands, pulses a start strobe to
//   the unit, stalls the pipeline while the unit works, and hands the result
//   to writeback for a single cycle. A watchdog ends an operation whose ready
//   never arrives and reports it as an exception.
//
// Handshakes:
//   issue -> stall : an operation is taken when issue is high with an op bit
//                    set while the controller is in IDLE or DONE. stall is
//                    combinational, so the front end sees it in the issue
//                    cycle and keeps re-presenting anything it issues while
//                    stall is high.
//   ctrl_* -> data_resultRDY : one registered start pulse per operation. RDY
//                    is only honoured in BUSY; any other cycle ignores it.
//   wb_valid       : one-cycle strobe; wb_data/wb_rd/wb_exception hold until
//                    the next completion.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   issue, op_is_div, op_is_mult operation request (DIV wins over MULT)
//   operand_A, operand_B, rd     operands and destination register
//   data_operandA/B              latched operands driven to the unit
//   ctrl_MULT, ctrl_DIV          start pulses to the unit
//   data_result, data_exception, data_resultRDY  unit response
//   stall                        front-end hold
//   wb_valid, wb_data, wb_rd, wb_exception       writeback bundle
//   dbg_state                    current FSM state (IDLE=0 START=1 BUSY=2 DONE=3)
module multdiv_ctrl #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue,
  input  logic        op_is_div,
  input  logic        op_is_mult,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  input  logic [4:0]  rd,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_exception,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] WD_LAST = 6'(MAX_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        timeout;
  logic        finish;
  logic [5:0]  wd_cnt;
  logic [4:0]  rd_q;

  // Gating with reset_n keeps stall and the start pulse quiet during reset.
  always_comb begin
    accept  = reset_n & issue & (op_is_div | op_is_mult) &
              ((state == IDLE) | (state == DONE));
    timeout = (wd_cnt == WD_LAST);
    finish  = (state == BUSY) & (data_resultRDY | timeout);
    stall   = accept | (state == START) | (state == BUSY);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = BUSY;   // RDY here may be left over from the last op
      BUSY:    if (data_resultRDY | timeout) state_nx = DONE;
      DONE:    state_nx = accept ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      ctrl_MULT     <= 1'b0;
      ctrl_DIV      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_exception  <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      data_operandA <= '0;
      data_operandB <= '0;
      rd_q          <= '0;
      wd_cnt        <= '0;
    end else begin
      state     <= state_nx;
      // Registered so the pulse is high exactly during START.
      ctrl_DIV  <= accept & op_is_div;
      ctrl_MULT <= accept & ~op_is_div;
      wb_valid  <= finish;

      // Operands are held until the next accept: the unit keeps reading
      // their sign bits right up to its final cycle.
      if (accept) begin
        data_operandA <= operand_A;
        data_operandB <= operand_B;
        rd_q          <= rd;
      end

      if (state == START) begin
        wd_cnt <= '0;
      end else if (state == BUSY) begin
        wd_cnt <= wd_cnt + 6'd1;
      end

      // rd is copied at completion so a back-to-back accept cannot disturb
      // the writeback register of the operation just finishing.
      if (finish) begin
        wb_rd <= rd_q;
        if (data_resultRDY) begin
          wb_data      <= data_result;
          wb_exception <= data_exception;
        end else begin
          wb_data      <= '0;
          wb_exception <= 1'b1;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: directed cases plus randomized operations.
// The bench plays the role of the multiply/divide unit and keeps a queue of
// expected writeback bundles computed from the operation's arithmetic.
module tb_multdiv_ctrl;

  localparam int MAXC = 40;
  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        issue, op_is_div, op_is_mult;
  logic [31:0] operand_A, operand_B;
  logic [4:0]  rd;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall, wb_valid, wb_exception;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  dbg_state;

  multdiv_ctrl #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset_n(reset_n), .issue(issue), .op_is_div(op_is_div),
    .op_is_mult(op_is_mult), .operand_A(operand_A), .operand_B(operand_B),
    .rd(rd), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_exception(wb_exception), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int n_start = 0, n_wb = 0, exp_start = 0, exp_wb = 0;
  logic [37:0] exp_q[$];   // {exception, rd, data}
  logic [37:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behaviour of the unit itself: {exception, result}.
  function automatic logic [32:0] unit_ref(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    if (!is_div) return {1'b0, a * b};
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
    return {1'b0, 32'($signed(a) / $signed(b))};
  endfunction

  always @(negedge clk) begin
    logic [37:0] e;
    if (ctrl_MULT === 1'b1 || ctrl_DIV === 1'b1) n_start++;
    if (wb_valid === 1'b1) begin
      n_wb++;
      check("wb_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_bundle", {wb_exception, wb_rd, wb_data}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Random traffic on inputs the controller must ignore or not follow.
  task automatic scramble();
    issue      = 1'($urandom_range(0, 1));
    op_is_div  = 1'($urandom_range(0, 1));
    op_is_mult = 1'($urandom_range(0, 1));
    operand_A  = $urandom;
    operand_B  = $urandom;
    rd         = 5'($urandom_range(0, 31));
  endtask

  // Called in a drive window with the DUT in IDLE or DONE. Returns in the
  // drive window of the DONE cycle with issue low.
  task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input int lat, input bit never,
                       input bit rdy_in_start, input bit from_done);
    logic [32:0] u;
    bit fin;
    issue      = 1'b1;
    op_is_div  = is_div;
    op_is_mult = is_div ? 1'($urandom_range(0, 1)) : 1'b1;
    operand_A  = a;
    operand_B  = b;
    rd         = r;
    data_resultRDY = 1'b0;
    u = unit_ref(is_div, a, b);
    last_exp = never ? {1'b1, r, 32'h0} : {u[32], r, u[31:0]};
    exp_q.push_back(last_exp);
    exp_start++;
    exp_wb++;
    @(negedge clk);
    check("stall_issue", stall, 1);
    check("wb_valid_issue", wb_valid, from_done);

    @(posedge clk); #1;
    scramble();
    data_resultRDY = rdy_in_start;
    data_result    = $urandom;
    data_exception = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("start_pulse", {ctrl_DIV, ctrl_MULT}, {is_div, ~is_div});
    check("stall_start", stall, 1);
    check("opA_start", data_operandA, a);
    check("opB_start", data_operandB, b);
    check("wb_start", wb_valid, 0);

    for (int i = 0; i < MAXC; i++) begin
      @(posedge clk); #1;
      scramble();
      fin = never ? (i == MAXC - 1) : (i == lat);
      if (!never && i == lat) begin
        u = unit_ref(is_div, data_operandA, data_operandB);
        data_resultRDY = 1'b1;
        data_result    = u[31:0];
        data_exception = u[32];
      end else begin
        data_resultRDY = 1'b0;
        data_result    = $urandom;
        data_exception = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("stall_busy", stall, 1);
      check("ctrl_busy", {ctrl_DIV, ctrl_MULT}, 0);
      check("wb_busy", wb_valid, 0);
      check("opA_busy", data_operandA, a);
      check("opB_busy", data_operandB, b);
      if (fin) break;
    end

    @(posedge clk); #1;
    issue          = 1'b0;
    op_is_div      = 1'b0;
    op_is_mult     = 1'b0;
    data_resultRDY = 1'($urandom_range(0, 1));
    data_result    = $urandom;
  endtask

  // Finish in DONE with no new issue, then poke a stale RDY in IDLE.
  task automatic finish_idle();
    @(negedge clk);
    check("wb_valid_done", wb_valid, 1);
    check("stall_done", stall, 0);
    @(posedge clk); #1;
    data_resultRDY = 1'b1;
    data_result    = $urandom;
    @(negedge clk);
    check("state_idle", dbg_state, ST_IDLE);
    check("wb_valid_idle", wb_valid, 0);
    check("stall_idle", stall, 0);
    check("wb_hold", {wb_exception, wb_rd, wb_data}, last_exp);
    @(posedge clk); #1;
    data_resultRDY = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit chain;
    logic [31:0] b;
    reset_n = 1'b0;
    issue = 1'b1; op_is_div = 1'b1; op_is_mult = 1'b0;
    operand_A = 32'd77; operand_B = 32'd3; rd = 5'd9;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;

    // Reset held 3 cycles with issue asserted.
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_ctrl_wb", {ctrl_MULT, ctrl_DIV, wb_valid, wb_exception, wb_rd}, 0);
      check("rst_operands", {data_operandA, data_operandB}, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    issue   = 1'b0;
    @(negedge clk);
    check("rel_ctrl0", {ctrl_MULT, ctrl_DIV}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_ctrl1", {ctrl_MULT, ctrl_DIV}, 0);
    @(posedge clk); #1;

    // DIV 100 / -7 -> -14, rd 5.
    do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 5'd5, 3, 0, 0, 0);
    finish_idle();
    check("div_example", last_exp, {1'b0, 5'd5, 32'hFFFF_FFF2});

    // DIV 42 / 0 with stale RDY in START -> exception.
    do_op(1'b1, 32'd42, 32'd0, 5'd9, 2, 0, 1, 0);
    finish_idle();

    // DIV then MULT 6 x 7 issued in the DONE cycle.
    do_op(1'b1, 32'd1000, 32'd3, 5'd7, 1, 0, 0, 0);
    do_op(1'b0, 32'd6, 32'd7, 5'd12, 0, 0, 0, 1);
    finish_idle();

    // Unit never answers: watchdog after MAX_CYCLES BUSY cycles.
    do_op(1'b0, 32'd11, 32'd13, 5'd3, 0, 1, 0, 0);
    finish_idle();

    // Reset in the middle of BUSY discards the operation.
    issue = 1'b1; op_is_div = 1'b0; op_is_mult = 1'b1;
    operand_A = 32'd5; operand_B = 32'd9; rd = 5'd4;
    exp_start++;
    @(posedge clk); #1;
    issue = 1'b0; op_is_mult = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_wb", wb_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    data_resultRDY = 1'b1;
    data_result = 32'd45;
    @(negedge clk);
    check("rstmid_state", dbg_state, ST_IDLE);
    check("rstmid_stall", stall, 0);
    check("rstmid_outs", {ctrl_MULT, ctrl_DIV, wb_valid}, 0);
    check("rstmid_ops", {data_operandA, data_operandB}, 0);
    @(posedge clk); #1;
    data_resultRDY = 1'b0;
    @(negedge clk);
    check("rstmid_nowb", wb_valid, 0);
    last_exp = '0;
    @(posedge clk); #1;

    // Randomized operations, some back-to-back.
    chain = 1'b0;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($signed(-$urandom_range(1, 20)));
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), $urandom, b, 5'($urandom_range(0, 31)),
            $urandom_range(0, 6), 0, 1'($urandom_range(0, 1)), chain);
      chain = 1'($urandom_range(0, 1));
      if (!chain) finish_idle();
    end
    if (chain) finish_idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("start_count", n_start, exp_start);
    check("wb_count", n_wb, exp_wb);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
